// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the data-memory load/store unit.
//   - SIZE_B / SIZE_H / SIZE_W / SIZE_X : req_size encodings (byte, half, word, illegal)
//   - lsu_state_t                       : FSM state encoding of data_mem_lsu
//   - lsu_req_err()                     : misalignment / illegal-size check for a request
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_LO  = 3'd1,
        ST_RD_HI  = 3'd2,
        ST_WR_LO  = 3'd3,
        ST_WR_HI  = 3'd4,
        ST_RMW_RD = 3'd5,
        ST_RMW_WR = 3'd6,
        ST_RESP   = 3'd7
    } lsu_state_t;

    // A request is rejected when its size is illegal or its address is not
    // naturally aligned for that size. Only the two low address bits matter.
    function automatic logic lsu_req_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        err = 1'b0;
        case (size)
            SIZE_H:  err = addr_lo[0];
            SIZE_W:  err = (addr_lo != 2'b00);
            SIZE_X:  err = 1'b1;
            default: err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational formation of a 32-bit load result.
//   lo, hi   in  16  halfwords read at idx and idx+1
//   size     in   2  access size (SIZE_B / SIZE_H / SIZE_W)
//   lane     in   1  byte lane for byte loads (0 = lo[7:0], 1 = lo[15:8])
//   is_uns   in   1  zero-extend instead of sign-extend
//   result   out 32  extended load data (0 for the illegal size)
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [15:0] lo,
    input  logic [15:0] hi,
    input  logic [1:0]  size,
    input  logic        lane,
    input  logic        is_uns,
    output logic [31:0] result
);

    logic [7:0] byte_sel;
    logic       fill_h;
    logic       fill_b;

    assign byte_sel = lane ? lo[15:8] : lo[7:0];
    assign fill_h   = ~is_uns & lo[15];
    assign fill_b   = ~is_uns & byte_sel[7];

    always_comb begin
        result = 32'd0;
        case (size)
            SIZE_W:  result = {hi, lo};
            SIZE_H:  result = {{16{fill_h}}, lo};
            SIZE_B:  result = {{24{fill_b}}, byte_sel};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: turns one 32-bit load/store into a sequence of 16-bit
// accesses to a combinational-read data memory.
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid / req_ready           request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned,
//   req_addr, req_wdata             request fields, sampled only at acceptance
//   rsp_valid, rsp_err, rsp_rdata   single-cycle response, no backpressure
//   mem_write_en, mem_addr,
//   mem_wdata, mem_rdata            16-bit memory port (ADDR_W halfword index)
//
// Handshake: a request transfers on a posedge where req_valid && req_ready.
// rsp_valid is a one-cycle pulse that the receiver must take unconditionally.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              accept;
    logic              we_q, uns_q, lane_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_hi;
    logic [31:0]       wdata_q;
    logic [15:0]       lo_q, hi_q;
    logic [31:0]       load_data;

    assign accept = req_valid && req_ready;
    // Word accesses are aligned, so idx_q is even and this never wraps.
    assign idx_hi = idx_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            lane_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SIZE_B;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            lo_q    <= 16'd0;
            hi_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                lane_q  <= req_addr[0];
                err_q   <= lsu_req_err(req_size, req_addr[1:0]);
                size_q  <= req_size;
                idx_q   <= req_addr[ADDR_W:1];
                wdata_q <= req_wdata;
            end
            if (state_q == ST_RD_LO || state_q == ST_RMW_RD) begin
                lo_q <= mem_rdata;
            end
            if (state_q == ST_RD_HI) begin
                hi_q <= mem_rdata;
            end
        end
    end

    lsu_load_ext u_load_ext (
        .lo     (lo_q),
        .hi     (hi_q),
        .size   (size_q),
        .lane   (lane_q),
        .is_uns (uns_q),
        .result (load_data)
    );

    // All outputs are held at 0 while rst_n is low, so a reset landing in a
    // write state suppresses that write before the clock edge arrives.
    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        rsp_rdata    = 32'd0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 16'd0;
        if (rst_n) begin
            case (state_q)
                ST_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (lsu_req_err(req_size, req_addr[1:0])) state_d = ST_RESP;
                        else if (!req_we)                         state_d = ST_RD_LO;
                        else if (req_size == SIZE_B)              state_d = ST_RMW_RD;
                        else                                      state_d = ST_WR_LO;
                    end
                end
                ST_RD_LO: begin
                    mem_addr = idx_q;
                    state_d  = (size_q == SIZE_W) ? ST_RD_HI : ST_RESP;
                end
                ST_RD_HI: begin
                    mem_addr = idx_hi;
                    state_d  = ST_RESP;
                end
                ST_WR_LO: begin
                    mem_write_en = 1'b1;
                    mem_addr     = idx_q;
                    mem_wdata    = wdata_q[15:0];
                    state_d      = (size_q == SIZE_W) ? ST_WR_HI : ST_RESP;
                end
                ST_WR_HI: begin
                    mem_write_en = 1'b1;
                    mem_addr     = idx_hi;
                    mem_wdata    = wdata_q[31:16];
                    state_d      = ST_RESP;
                end
                ST_RMW_RD: begin
                    mem_addr = idx_q;
                    state_d  = ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    // Replace only the addressed byte of the captured halfword.
                    mem_write_en = 1'b1;
                    mem_addr     = idx_q;
                    mem_wdata    = lane_q ? {wdata_q[7:0], lo_q[7:0]} : {lo_q[15:8], wdata_q[7:0]};
                    state_d      = ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid = 1'b1;
                    rsp_err   = err_q;
                    rsp_rdata = (err_q || we_q) ? 32'd0 : load_data;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store initiator between the CPU execute stage and the 16-bit-wide data memory. It turns one 32-bit RISC-V load or store (byte, halfword, word; signed or unsigned loads) into a sequence of 16-bit memory accesses. Sub-halfword stores use read-modify-write. Each request returns a single-cycle response carrying the read data or a misalignment error.

## Interface
Parameters:
- ADDR_W, 6: halfword index width of the attached memory (6 = 64×16b, 9 = 512×16b).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high in IDLE only; a request is accepted when req_valid && req_ready at posedge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: zero-extend, else sign-extend.
- req_addr  in  32  byte address; bits above ADDR_W ignored.
- req_wdata  in  32  store data, little-endian lanes.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_err  out  1  valid with rsp_valid: misaligned or illegal size.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- mem_write_en  out  1  to memory write_en.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  16  to memory data_in.
- mem_rdata  in  16  from memory data_out (combinational read, same cycle as mem_addr).

## Operation
- Halfword index idx = addr[ADDR_W:1]. Word = halfwords idx (low) and idx+1 (high). Byte lane = addr[0]: 0 selects [7:0], 1 selects [15:8].
- Error conditions: word with addr[1:0]≠0, half with addr[0]≠0, or size 11. The request goes straight to RESP with rsp_err=1 and no memory access.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RMW_RD, RMW_WR, RESP.
- Accept in IDLE: latch request fields.
  - Error → RESP.
  - Load → RD_LO.
  - Store word or half → WR_LO.
  - Store byte → RMW_RD.
- RD_LO: mem_addr=idx; capture mem_rdata into lo. Next state: word → RD_HI, else → RESP.
- RD_HI: mem_addr=idx+1; capture into hi → RESP.
- WR_LO: mem_write_en=1, mem_addr=idx, mem_wdata=wdata[15:0]. Next state: word → WR_HI, else → RESP.
- WR_HI: mem_write_en=1, mem_addr=idx+1, mem_wdata=wdata[31:16] → RESP.
- RMW_RD: mem_addr=idx; capture the halfword → RMW_WR.
- RMW_WR: mem_write_en=1, mem_addr=idx; write the captured halfword with the selected lane replaced by wdata[7:0] → RESP.
- RESP: rsp_valid=1 → IDLE.
- rsp_rdata formation:
  - Word: {hi, lo}.
  - Half: lo, extended to 32 bits.
  - Byte: selected lane, extended to 32 bits.
  - Extension is sign unless req_unsigned.
- In all other states: mem_write_en=0, mem_addr=0, mem_wdata=0.

## Timing
- Latency, counted from acceptance edge T to the rsp_valid cycle:
  - Error: T+1.
  - lh, lb, sh: T+2.
  - lw, sw, sb: T+3.
- Throughput: the next request is accepted on the edge that leaves RESP. There is no overlap between requests.
- Memory writes commit on the posedge that ends the WR_*/RMW_WR cycle.
- Reset values: state IDLE; all outputs 0, including req_ready. While rst_n=0, mem_write_en is forced 0 combinationally.
- Reset mid-operation: the FSM returns to IDLE, the response is dropped, and no further writes occur. A word store reset after WR_LO leaves only the low half written; this is acceptable.
- Word accesses are aligned, so idx is even and idx+1 never wraps. Address bits above ADDR_W alias silently.
- req_* inputs are sampled only at acceptance. Later changes to them are ignored.

## Structure
- Shared package lsu_pkg: size encodings SIZE_B/SIZE_H/SIZE_W, the state enum, and the lsu_state_t typedef.
- One combinational sub-module, lsu_load_ext: (halfword lo, hi, size, lane, unsigned) → 32-bit result. The RMW merge stays inline.

## Test plan
- Memory preset [4]=16'h5678, [5]=16'h1234. lw addr 0x08 → rsp at T+3, rdata=32'h12345678, err=0.
- sb wdata 0xAB, addr 0x09, with [4]=16'h5678 → [4]=16'hAB78 after T+3, [5] unchanged, exactly one write pulse.
- lb addr 0x09 on [4]=16'hAB78 → rdata=32'hFFFFFFAB. The same access with req_unsigned=1 → 32'h000000AB.
- sw wdata 32'hDEADBEEF, addr 0x10 → [8]=16'hBEEF, [9]=16'hDEAD; rsp at T+3, rdata=0.
- lw addr 0x02, and separately lh addr 0x03 → rsp at T+1 with err=1; mem_write_en never asserted; memory unchanged.
- sw accepted, rst_n pulled low during WR_HI → no write that cycle, req_ready=0 during reset, FSM in IDLE with outputs 0 after reset.
